// File: rtl/rca_wide_add_seq.sv
// Multi-byte add/subtract sequencer: feeds an external 8-bit ripple-carry adder
// one limb per cycle (LSB first) and assembles the WORDS*8-bit result.
module rca_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8*WORDS-1:0]   op_a,
  input  logic [8*WORDS-1:0]   op_b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [8*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 overflow,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_cin,
  input  logic [7:0]           add_s,
  input  logic                 add_cout
);

  localparam int W  = 8 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, one limb per RUN cycle
  always_comb begin
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          // Subtraction runs as A + ~B + (1 - borrow_in)
          b_d     = sub ? ~op_b : op_b;
          carry_d = cin ^ sub;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q;
        end
      end
      S_RUN: begin
        result_d[8*idx_q +: 8] = add_s;
        carry_d                = add_cout;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          cout_d = add_cout;
          ovf_d  = (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);
        end else begin
          idx_d  = idx_q + IW'(1);
        end
      end
      S_DONE:  idx_d = idx_q;
      default: idx_d = idx_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Output decode; adder drive is combinational so the limb result lands the same cycle
  always_comb begin
    ready   = (state_q == S_IDLE);
    busy    = (state_q == S_RUN);
    done    = (state_q == S_DONE);
    if (state_q == S_RUN) begin
      add_a   = a_q[8*idx_q +: 8];
      add_b   = b_q[8*idx_q +: 8];
      add_cin = carry_q;
    end else begin
      add_a   = 8'd0;
      add_b   = 8'd0;
      add_cin = 1'b0;
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_rca_wide_add_seq.sv
// Bench for rca_wide_add_seq: directed test-plan steps plus random operations
// checked against an integer-arithmetic reference model.
module tb_rca_wide_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  op_a, op_b;
  logic          cin, sub;
  logic          ready, busy, done;
  logic [W-1:0]  result;
  logic          cout, overflow;
  logic [7:0]    add_a, add_b, add_s;
  logic          add_cin, add_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External combinational byte adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  rca_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .cin(cin), .sub(sub), .ready(ready), .busy(busy), .done(done),
    .result(result), .cout(cout), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Exactly one of ready/busy/done at all times
  always @(negedge clk) chk("one_hot", 64'($countones({ready, busy, done})), 64'd1);

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c, input logic s,
                                output logic [W-1:0] r, output logic co, output logic ov);
    logic [63:0] u;
    longint sa, sb, ci, sv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = c ? 64'sd1 : 64'sd0;
    if (!s) begin
      u  = {32'd0, a} + {32'd0, b} + {63'd0, c};
      co = u[W];
      sv = sa + sb + ci;
    end else begin
      u  = {32'd0, a} - {32'd0, b} - {63'd0, c};
      co = ~u[63];
      sv = sa - sb - ci;
    end
    r  = u[W-1:0];
    ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
  endfunction

  // Carry entering limb k of A + B' + c0, from whole-number arithmetic
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] bp,
                                      input logic c0, input int k);
    logic [63:0] mask, tot;
    mask = (64'd1 << (8 * k)) - 64'd1;
    tot  = ({32'd0, a} & mask) + ({32'd0, bp} & mask) + {63'd0, c0};
    return tot[8*k];
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s, input bit inject, input string tag);
    logic [W-1:0] er, bp;
    logic         eco, eov;
    int           n, k;
    model(a, b, c, s, er, eco, eov);
    bp = s ? ~b : b;
    @(negedge clk);
    chk({tag, "_ready_before"}, 64'(ready), 64'd1);
    start = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0; op_a = $urandom; op_b = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      if (busy) begin
        k = n - 1;
        chk({tag, "_add_a"},   64'(add_a),   64'(a[8*k +: 8]));
        chk({tag, "_add_b"},   64'(add_b),   64'(bp[8*k +: 8]));
        chk({tag, "_add_cin"}, 64'(add_cin), 64'(carry_into(a, bp, c ^ s, k)));
        if (inject && n == 2) begin
          start = 1'b1; op_a = 32'hAAAAAAAA;
        end
      end
    end while (!done && n < 20);
    chk({tag, "_latency"},  64'(n),        64'(WORDS + 1));
    chk({tag, "_result"},   64'(result),   64'(er));
    chk({tag, "_cout"},     64'(cout),     64'(eco));
    chk({tag, "_overflow"}, 64'(overflow), 64'(eov));
    if (inject) begin
      start = 1'b1; op_a = 32'hAAAAAAAA;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, 64'(done),   64'd0);
    chk({tag, "_ready_after"}, 64'(ready), 64'd1);
    chk({tag, "_held"},       64'(result), 64'(er));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  64'(ready),    64'd1);
    chk("rst_busy",   64'(busy),     64'd0);
    chk("rst_done",   64'(done),     64'd0);
    chk("rst_result", 64'(result),   64'd0);
    chk("rst_cout",   64'(cout),     64'd0);
    chk("rst_ovf",    64'(overflow), 64'd0);
    chk("rst_add",    64'({add_a, add_b, add_cin}), 64'd0);
    rst_n = 1'b1;

    do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, "t1");
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, "t2a");
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, "t2b");
    do_op(32'h12345678, 32'h11111111, 1'b1, 1'b0, 1'b0, "t3");
    do_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, "t4a");
    do_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b0, "t4b");
    do_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, "sub_ovf");
    do_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, "t5");

    // Abort mid-RUN once limb 1 has been captured
    @(negedge clk);
    start = 1'b1; op_a = 32'h01020304; op_b = 32'h10203040; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy",   64'(busy),   64'd0);
    chk("t6_ready",  64'(ready),  64'd1);
    chk("t6_result", 64'(result), 64'd0);
    chk("t6_add",    64'({add_a, add_b, add_cin}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    do_op(32'hCAFEBABE, 32'h01234567, 1'b1, 1'b0, 1'b0, "t6_after");

    for (int i = 0; i < 40; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_wide_add_seq.md
Name: rca_wide_add_seq

Overview:
- Sequencer that performs a WORDS×8-bit add or subtract by driving one shared 8-bit ripple-carry adder one byte per cycle, least-significant byte first.
- The adder is instantiated outside this block and is purely combinational.
- The block sits between a requester (start/ready/done handshake) and the adder's a/b/cin/s/cout ports.
- It holds operands, the running carry and the assembled result.

Parameters:
- WORDS, 4, number of 8-bit limbs; operand width is W = 8*WORDS. Legal range is 2..16.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when ready=1
- op_a  input  W  operand A; captured when start is accepted
- op_b  input  W  operand B; captured when start is accepted
- cin  input  1  carry-in (add) or borrow-in (sub); captured with start
- sub  input  1  0 = A+B+cin, 1 = A−B−cin; captured with start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  single-cycle pulse; result/cout/overflow are valid while it is high
- result  output  W  final sum or difference; held until the next accepted start
- cout  output  1  final carry out; for sub, 1 = no borrow
- overflow  output  1  two's-complement signed overflow of the final result
- add_a  output  8  byte of A driven to the adder
- add_b  output  8  byte of B', driven to the adder
- add_cin  output  1  running carry driven to the adder
- add_s  input  8  adder sum, combinational from add_a/add_b/add_cin
- add_cout  input  1  adder carry out

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, idx=0, carry=0.
  - Operand and result registers are 0; cout=0, overflow=0, done=0, busy=0, ready=1.
  - add_a, add_b and add_cin are 0.
  - Reset asserted in any state, including mid-RUN, aborts the operation with no done pulse.
- FSM states:
  - IDLE → RUN when start=1.
  - RUN → DONE on the edge where idx=WORDS-1.
  - DONE → IDLE unconditionally.
- Accept (IDLE, start=1):
  - A ← op_a.
  - B' ← sub ? ~op_b : op_b.
  - carry ← cin ^ sub. With sub=1, cin=0 gives A−B; cin=1 gives A−B−1.
  - idx ← 0.
  - The result register is not cleared on accept.
- RUN, each cycle:
  - add_a = A[8*idx +: 8], add_b = B'[8*idx +: 8], add_cin = carry.
  - At the clock edge: result[8*idx +: 8] ← add_s, carry ← add_cout, idx ← idx+1.
- Last word (idx=WORDS-1):
  - cout ← add_cout.
  - overflow ← (A[W-1] == B'[W-1]) && (add_s[7] != A[W-1]).
- Adder drive outside RUN: add_a, add_b and add_cin are 0.
- DONE: done=1 for exactly one cycle; busy=0; ready=0.
- Latency:
  - start is accepted at edge E0.
  - Word k is computed during the cycle after edge E(k) and captured at edge E(k+1).
  - done is high during the cycle after edge E(WORDS).
  - ready returns after edge E(WORDS+1).
  - Throughput is one operation per WORDS+2 cycles.
- start while busy=1 or done=1 is ignored. Operands and sub are not re-sampled, and no queueing occurs.
- op_a, op_b, cin and sub may change freely after acceptance without affecting the operation in flight.
- Widths and wrap: result is modulo 2^W. The final carry goes to cout only and is never wrapped into result.
- Assertions for the bench:
  - busy, ready and done are mutually exclusive, and exactly one is high.
  - idx never exceeds WORDS-1.

Test Plan:
1. WORDS=4, A=0x000000FF, B=0x00000001, cin=0, sub=0 → result=0x00000100, cout=0, overflow=0. done rises exactly 5 cycles after the start cycle; add_cin=1 during word 1.
2. A=0xFFFFFFFF, B=0x00000001, sub=0 → result=0x00000000, cout=1, overflow=0. Then A=0x7FFFFFFF, B=0x00000001 → result=0x80000000, cout=0, overflow=1.
3. A=0x12345678, B=0x11111111, cin=1, sub=0 → result=0x2345678A, cout=0. Also check add_a/add_b per cycle: 0x78/0x11, then 0x56/0x11, then 0x34/0x11, then 0x12/0x11.
4. sub=1, A=0x00000005, B=0x00000007, cin=0 → result=0xFFFFFFFE, cout=0 (borrow), overflow=0. Repeat with cin=1 → result=0xFFFFFFFD.
5. Start add 0x00000001+0x00000001. Pulse start with A=0xAAAAAAAA during RUN and again during DONE → both ignored; result=0x00000002; ready=1 the cycle after done.
6. Assert rst_n=0 mid-RUN after word 1 → asynchronously busy=0, ready=1, result=0, add_* outputs=0, no done pulse. A new start after release completes normally with correct values.
